// File: rtl/ram_pkg.sv
// Shared constants for the banked data RAM: FSM encoding and default geometry.
package ram_pkg;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_BANK_ADDR_W = 3;
    localparam int unsigned DEF_WORD_ADDR_W = 9;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: synchronous write, read-first registered output.
module ram_bank
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned ADDR_W = DEF_WORD_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Contents are never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_ram.sv
// Banked data RAM with registered read port and a hardware clear engine
// that zeroes one word index in every bank per cycle.
module banked_ram
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned BANK_ADDR_W = DEF_BANK_ADDR_W,
    parameter int unsigned WORD_ADDR_W = DEF_WORD_ADDR_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [WIDTH-1:0]                   in,
    input  logic [BANK_ADDR_W+WORD_ADDR_W-1:0] addr,
    input  logic                               load,
    input  logic                               rd_en,
    input  logic                               clr_req,
    output logic [WIDTH-1:0]                   out,
    output logic                               out_valid,
    output logic                               busy
);

    localparam int unsigned NBANKS = 1 << BANK_ADDR_W;
    localparam int unsigned AW     = BANK_ADDR_W + WORD_ADDR_W;
    localparam logic [WORD_ADDR_W-1:0] LAST_IDX = '1;

    logic [0:0]             state_q, state_d;
    logic [WORD_ADDR_W-1:0] cnt_q, cnt_d;
    logic [BANK_ADDR_W-1:0] sel_q;
    logic                   valid_q;

    logic [BANK_ADDR_W-1:0] bank_sel;
    logic [WORD_ADDR_W-1:0] word_idx;
    logic                   idle, clearing, acc_wr, acc_rd;
    logic [WORD_ADDR_W-1:0] bank_addr;
    logic [WIDTH-1:0]       bank_wdata;
    logic [NBANKS-1:0]      bank_we, bank_re;
    logic [WIDTH-1:0]       bank_rdata [NBANKS];

    assign bank_sel = addr[AW-1:WORD_ADDR_W];
    assign word_idx = addr[WORD_ADDR_W-1:0];

    // A clear request wins over a same-cycle user access.
    assign idle     = (state_q == IDLE);
    assign acc_wr   = idle && load && !clr_req;
    assign acc_rd   = idle && rd_en && !clr_req;
    assign clearing = (state_q == CLEAR) && rst_n;

    assign bank_addr  = clearing ? cnt_q : word_idx;
    assign bank_wdata = clearing ? '0 : in;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        assign bank_we[b] = clearing || (acc_wr && (bank_sel == BANK_ADDR_W'(b)));
        assign bank_re[b] = acc_rd && (bank_sel == BANK_ADDR_W'(b));

        ram_bank #(
            .WIDTH  (WIDTH),
            .ADDR_W (WORD_ADDR_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (bank_we[b]),
            .re_i    (bank_re[b]),
            .addr_i  (bank_addr),
            .wdata_i (bank_wdata),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (clr_req) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + WORD_ADDR_W'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= acc_rd;
            if (acc_rd) begin
                sel_q <= bank_sel;
            end
        end
    end

    assign out       = bank_rdata[sel_q];
    assign out_valid = valid_q;
    assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_banked_ram.sv
// Randomised self-checking bench for banked_ram (default and small geometry).
module tb_banked_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic [11:0] addr;
    logic        load, rd_en, clr_req;
    logic [15:0] dout;
    logic        out_valid, busy;

    logic [7:0]  s_in;
    logic [4:0]  s_addr;
    logic        s_load, s_rd, s_clr;
    logic [7:0]  s_out;
    logic        s_valid, s_busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl [4096];

    always #5 clk = ~clk;

    banked_ram dut (
        .clk(clk), .rst_n(rst_n), .in(din), .addr(addr), .load(load),
        .rd_en(rd_en), .clr_req(clr_req), .out(dout), .out_valid(out_valid), .busy(busy)
    );

    banked_ram #(.WIDTH(8), .BANK_ADDR_W(1), .WORD_ADDR_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .in(s_in), .addr(s_addr), .load(s_load),
        .rd_en(s_rd), .clr_req(s_clr), .out(s_out), .out_valid(s_valid), .busy(s_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        addr = a; din = d; load = 1'b1;
        tick;
        load = 1'b0;
        mdl[a] = d;
    endtask

    task automatic rd(input logic [11:0] a, output logic [15:0] q, output logic v);
        addr = a; rd_en = 1'b1;
        tick;
        q = dout; v = out_valid;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_out: got %h want 0000", dout); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_clear;
        logic [15:0] q;
        logic        v;
        int          n;
        int          bad_valid;
        logic [11:0] ck [4];
        ck[0] = 12'h000; ck[1] = 12'h5FF; ck[2] = 12'hFFF; ck[3] = 12'h123;
        wr(12'h000, 16'hFFFF);
        wr(12'h5FF, 16'hFFFF);
        wr(12'hFFF, 16'hFFFF);
        clr_req = 1'b1; rd_en = 1'b1; addr = 12'h000;
        tick;
        clr_req = 1'b0; rd_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_drops_read: out_valid %b want 0", out_valid); end
        n = 0; bad_valid = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            load = (n == 200); rd_en = (n == 300); clr_req = (n == 400);
            addr = 12'h123; din = 16'hBEEF;
            tick;
            if (out_valid !== 1'b0) bad_valid++;
        end
        load = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        for (int i = 0; i < 4096; i++) mdl[i] = 16'h0;
        checks++; if (n != 512) begin errors++; $display("FAIL clr_busy_len: got %0d cycles want 512", n); end
        checks++; if (bad_valid != 0) begin errors++; $display("FAIL clr_valid_low: %0d cycles valid, want 0", bad_valid); end
        for (int i = 0; i < 4; i++) begin
            rd(ck[i], q, v);
            checks++;
            if (q !== mdl[ck[i]] || v !== 1'b1)
                begin errors++; $display("FAIL clr_readback[%h]: got %h/%b want %h/1", ck[i], q, v, mdl[ck[i]]); end
        end
    endtask

    task automatic test_bank_isolation;
        logic [15:0] q;
        logic        v;
        logic [11:0] a [3];
        a[0] = 12'h000; a[1] = 12'hE00; a[2] = 12'h200;
        wr(12'h200, 16'h5555);
        wr(12'h000, 16'h1234);
        wr(12'hE00, 16'hABCD);
        for (int i = 0; i < 3; i++) begin
            rd(a[i], q, v);
            checks++;
            if (q !== mdl[a[i]] || v !== 1'b1)
                begin errors++; $display("FAIL iso_read[%h]: got %h/%b want %h/1", a[i], q, v, mdl[a[i]]); end
        end
        addr = 12'h000;
        tick;
        checks++;
        if (dout !== 16'h5555 || out_valid !== 1'b0)
            begin errors++; $display("FAIL iso_hold: got %h/%b want 5555/0", dout, out_valid); end
    endtask

    task automatic test_collision;
        logic [15:0] q;
        logic        v;
        wr(12'h042, 16'h1111);
        addr = 12'h042; din = 16'h2222; load = 1'b1; rd_en = 1'b1;
        tick;
        load = 1'b0; rd_en = 1'b0;
        checks++;
        if (dout !== 16'h1111 || out_valid !== 1'b1)
            begin errors++; $display("FAIL collide_old: got %h/%b want 1111/1", dout, out_valid); end
        mdl[12'h042] = 16'h2222;
        rd(12'h042, q, v);
        checks++;
        if (q !== 16'h2222 || v !== 1'b1)
            begin errors++; $display("FAIL collide_new: got %h/%b want 2222/1", q, v); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] a [16];
        for (int i = 0; i < 16; i++) begin
            a[i] = 12'($urandom);
            wr(a[i], 16'($urandom));
        end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr = a[i];
            tick;
            checks++;
            if (dout !== mdl[a[i]] || out_valid !== 1'b1)
                begin errors++; $display("FAIL b2b[%0d] addr %h: got %h/%b want %h/1", i, a[i], dout, out_valid, mdl[a[i]]); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_random_traffic;
        logic [15:0] exp_q;
        logic [15:0] last = 16'h0;
        logic        have_last = 1'b0;
        logic        l, r;
        logic [11:0] a;
        logic [15:0] d;
        for (int i = 0; i < 300; i++) begin
            l = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 2) != 0);
            a = 12'($urandom);
            if (i % 3 == 0) a[8:0] = 9'h0A5;
            d = 16'($urandom);
            addr = a; din = d; load = l; rd_en = r;
            exp_q = mdl[a];
            tick;
            if (l) mdl[a] = d;
            checks++;
            if (r) begin
                if (dout !== exp_q || out_valid !== 1'b1)
                    begin errors++; $display("FAIL rand[%0d] read %h: got %h/%b want %h/1", i, a, dout, out_valid, exp_q); end
                last = exp_q; have_last = 1'b1;
            end else begin
                if (out_valid !== 1'b0 || (have_last && dout !== last))
                    begin errors++; $display("FAIL rand[%0d] hold: got %h/%b want %h/0", i, dout, out_valid, last); end
            end
        end
        load = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_clear;
        logic [15:0] q;
        logic        v;
        logic [11:0] a;
        int          n;
        for (int b = 0; b < 8; b++) begin
            wr({3'(b), 9'd50}, 16'hC000 + 16'(b));
            wr({3'(b), 9'd300}, 16'hD000 + 16'(b));
        end
        clr_req = 1'b1;
        tick;
        clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        checks++; if (n != 100) begin errors++; $display("FAIL midclr_busy: busy for %0d cycles want 100", n); end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || dout !== 16'h0)
            begin errors++; $display("FAIL midclr_reset: busy/valid/out %b/%b/%h want 0/0/0000", busy, out_valid, dout); end
        for (int b = 0; b < 8; b++) mdl[{3'(b), 9'd50}] = 16'h0;
        for (int b = 0; b < 8; b++) begin
            a = {3'(b), 9'd50};
            rd(a, q, v);
            checks++;
            if (q !== mdl[a] || v !== 1'b1) begin errors++; $display("FAIL midclr_w50[%0d]: got %h/%b want %h/1", b, q, v, mdl[a]); end
            a = {3'(b), 9'd300};
            rd(a, q, v);
            checks++;
            if (q !== mdl[a] || v !== 1'b1) begin errors++; $display("FAIL midclr_w300[%0d]: got %h/%b want %h/1", b, q, v, mdl[a]); end
        end
    endtask

    task automatic test_small_params;
        int n;
        for (int i = 0; i < 32; i++) begin
            s_addr = 5'(i); s_in = 8'(i); s_load = 1'b1;
            tick;
        end
        s_load = 1'b0; s_rd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            s_addr = 5'(i);
            tick;
            checks++;
            if (s_out !== 8'(i) || s_valid !== 1'b1)
                begin errors++; $display("FAIL small_read[%0d]: got %h/%b want %h/1", i, s_out, s_valid, 8'(i)); end
        end
        s_rd = 1'b0; s_clr = 1'b1;
        tick;
        s_clr = 1'b0;
        n = 0;
        while (s_busy === 1'b1 && n < 200) begin
            n++;
            tick;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL small_clr_len: got %0d want 16", n); end
        s_rd = 1'b1;
        for (int i = 0; i < 32; i += 7) begin
            s_addr = 5'(i);
            tick;
            checks++;
            if (s_out !== 8'h00 || s_valid !== 1'b1)
                begin errors++; $display("FAIL small_clr_read[%0d]: got %h/%b want 00/1", i, s_out, s_valid); end
        end
        s_rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; addr = '0; load = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        s_in = '0; s_addr = '0; s_load = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
        test_reset;
        test_clear;
        test_bank_isolation;
        test_collision;
        test_back_to_back;
        test_random_traffic;
        test_reset_mid_clear;
        test_small_params;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
